// File: rtl/vga_compositor.sv
// Two-stage pixel compositor: tag decode / overlay priority, then register-file colour lookup.
// Optional blink of overlay 0 is built when VGA_COMP_BLINK_EN is defined.
module vga_compositor #(
    parameter int PIXEL_W      = 8,
    parameter int NUM_COLORS   = 4,
    parameter int NUM_OVERLAYS = 2,
    parameter int GRAY_BITS    = 4,
    parameter int DEFER_WRITES = 1,
    parameter int BLINK_LOG2   = 5
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic [PIXEL_W-1:0]                              pixel_in,
    input  logic [NUM_OVERLAYS-1:0]                         overlay_in,
    input  logic                                            valid_in,
    input  logic                                            hsync_in,
    input  logic                                            vsync_in,
    input  logic                                            blank_in,
    input  logic                                            frame_start,
    input  logic                                            pal_we,
    input  logic [$clog2(NUM_COLORS+NUM_OVERLAYS+1)-1:0]    pal_addr,
    input  logic [11:0]                                     pal_data,
    output logic                                            pal_ready,
    output logic [11:0]                                     pixel_out,
    output logic                                            valid_out,
    output logic                                            hsync_out,
    output logic                                            vsync_out,
    output logic                                            blank_out
);
    localparam int R  = NUM_COLORS + NUM_OVERLAYS + 1;
    localparam int RA = $clog2(R);
    localparam int IW = PIXEL_W - 2;

    localparam logic [0:0] SLOT_EMPTY   = 1'b0;
    localparam logic [0:0] SLOT_PENDING = 1'b1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } timing_t;

    function automatic logic [11:0] rst_val(input int k);
        logic [11:0] v;
        v = 12'hFFF;
        if (k < NUM_COLORS) begin
            case (k)
                0: v = 12'hFF0;
                1: v = 12'hA26;
                2: v = 12'h0F0;
                3: v = 12'hF00;
                default: v = 12'hFFF;
            endcase
        end else if (k < NUM_COLORS + NUM_OVERLAYS) begin
            case (k - NUM_COLORS)
                0: v = 12'h00F;
                1: v = 12'hA26;
                default: v = 12'hFFF;
            endcase
        end
        return v;
    endfunction

    logic [11:0] regs [R];

    logic [0:0]    slot_state;
    logic [RA-1:0] slot_addr;
    logic [11:0]   slot_data;
    logic          commit;

    assign pal_ready = (slot_state == SLOT_EMPTY);
    // Capture while EMPTY, so a frame_start coincident with capture is never the commit pulse.
    assign commit = (slot_state == SLOT_PENDING) && ((DEFER_WRITES == 0) || frame_start);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_state <= SLOT_EMPTY;
            slot_addr  <= '0;
            slot_data  <= '0;
        end else if (slot_state == SLOT_EMPTY) begin
            if (pal_we) begin
                slot_state <= SLOT_PENDING;
                slot_addr  <= pal_addr;
                slot_data  <= pal_data;
            end
        end else if (commit) begin
            slot_state <= SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < R; k++) regs[k] <= rst_val(k);
        end else if (commit && (int'(slot_addr) < R)) begin
            regs[slot_addr] <= slot_data;
        end
    end

    logic [NUM_OVERLAYS-1:0] ov_eff;

`ifdef VGA_COMP_BLINK_EN
    logic [BLINK_LOG2-1:0] blink_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in)           blink_cnt <= '0;
        else if (frame_start) blink_cnt <= blink_cnt + 1'b1;
    end

    assign ov_eff = overlay_in & ~NUM_OVERLAYS'(blink_cnt[BLINK_LOG2-1]);
`else
    assign ov_eff = overlay_in;
`endif

    logic [1:0]    tag;
    logic [IW-1:0] idx;
    logic [IW-1:0] gray_top;
    logic          sel_gray;
    logic [RA-1:0] sel_idx;
    logic [3:0]    sel_g;

    assign tag = pixel_in[PIXEL_W-1 -: 2];
    assign idx = pixel_in[IW-1:0];

    always_comb begin
        sel_gray = 1'b1;
        sel_idx  = RA'(R - 1);
        gray_top = idx >> (IW - GRAY_BITS);
        sel_g    = 4'(gray_top) << (4 - GRAY_BITS);
        if (tag == 2'b11) begin
            sel_gray = 1'b0;
            if (int'(idx) < NUM_COLORS) sel_idx = RA'(idx);
        end
        // Walk high-to-low so the lowest set overlay bit wins.
        for (int i = NUM_OVERLAYS - 1; i >= 0; i--) begin
            if (ov_eff[i]) begin
                sel_gray = 1'b0;
                sel_idx  = RA'(NUM_COLORS + i);
            end
        end
    end

    logic          s1_gray;
    logic [RA-1:0] s1_idx;
    logic [3:0]    s1_g;
    logic [2:1]    vld_pipe;
    timing_t [2:1] tim_pipe;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_gray   <= 1'b0;
            s1_idx    <= '0;
            s1_g      <= '0;
            vld_pipe  <= '0;
            tim_pipe  <= '0;
            pixel_out <= '0;
        end else begin
            s1_gray  <= sel_gray;
            s1_idx   <= sel_idx;
            s1_g     <= sel_g;
            vld_pipe <= {vld_pipe[1], valid_in};
            tim_pipe <= {tim_pipe[1], timing_t'{hsync_in, vsync_in, blank_in}};
            if (!vld_pipe[1])  pixel_out <= 12'h000;
            else if (s1_gray)  pixel_out <= {s1_g, s1_g, s1_g};
            else               pixel_out <= regs[s1_idx];
        end
    end

    assign valid_out = vld_pipe[2];
    assign hsync_out = tim_pipe[2].hsync;
    assign vsync_out = tim_pipe[2].vsync;
    assign blank_out = tim_pipe[2].blank;

endmodule
